// File: rtl/operand_issue.sv
// Operand-issue stage: scoreboard hazard check, register-file read with
// writeback bypass, and a single registered skid-free output slot.
module operand_issue #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  output logic [ADDR_WIDTH-1:0] raddr1,
  output logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_wen,
  output logic                  idle
);
  localparam int unsigned NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy_q, busy_d;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_pc_q, out_imm_q, out_src1_q, out_src2_q;
  logic [CTRL_WIDTH-1:0] out_ctrl_q;
  logic [ADDR_WIDTH-1:0] out_rd_q;
  logic                  out_rd_wen_q;

  logic                  wb_en;
  logic                  wbhit_rs1, wbhit_rs2, wbhit_rd;
  logic                  rd_writes;
  logic                  hazard, accept;
  logic [DATA_WIDTH-1:0] src1, src2;

  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  assign wb_en     = wb_valid && (wb_addr != '0);
  assign wbhit_rs1 = wb_en && (wb_addr == in_rs1);
  assign wbhit_rs2 = wb_en && (wb_addr == in_rs2);
  assign wbhit_rd  = wb_en && (wb_addr == in_rd);
  assign rd_writes = in_rd_wen && (in_rd != '0);

  // A writeback landing this cycle resolves the dependency it would stall on.
  assign hazard = in_valid && ((busy_q[in_rs1] && !wbhit_rs1) ||
                               (busy_q[in_rs2] && !wbhit_rs2) ||
                               (rd_writes && busy_q[in_rd] && !wbhit_rd));

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign src1 = (in_rs1 == '0) ? '0 : (wbhit_rs1 ? wb_data : rdata1);
  assign src2 = (in_rs2 == '0) ? '0 : (wbhit_rs2 ? wb_data : rdata2);

  // Clear is applied before set so a same-cycle re-issue keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)
      busy_d[wb_addr] = 1'b0;
    if (accept && rd_writes)
      busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_imm_q    <= '0;
      out_src1_q   <= '0;
      out_src2_q   <= '0;
      out_ctrl_q   <= '0;
      out_rd_q     <= '0;
      out_rd_wen_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        out_valid_q  <= 1'b1;
        out_pc_q     <= in_pc;
        out_imm_q    <= in_imm;
        out_src1_q   <= src1;
        out_src2_q   <= src2;
        out_ctrl_q   <= in_ctrl;
        out_rd_q     <= in_rd;
        out_rd_wen_q <= in_rd_wen;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_imm    = out_imm_q;
  assign out_src1   = out_src1_q;
  assign out_src2   = out_src2_q;
  assign out_ctrl   = out_ctrl_q;
  assign out_rd     = out_rd_q;
  assign out_rd_wen = out_rd_wen_q;
  assign idle       = (busy_q == '0) && !out_valid_q;

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, operand/PC width.
REQ-003 SHALL have parameter CTRL_WIDTH, default 16, opaque decoded-control width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1 / in_ready output 1  upstream decode handshake.
REQ-007 SHALL have ports in_pc, in_imm  input  DATA_WIDTH  instruction payload.
REQ-008 SHALL have port in_ctrl  input  CTRL_WIDTH  passed through unchanged.
REQ-009 SHALL have ports in_rs1, in_rs2, in_rd  input  ADDR_WIDTH  source/dest indices.
REQ-010 SHALL have port in_rd_wen  input  1  instruction writes rd.
REQ-011 SHALL have ports raddr1, raddr2  output  ADDR_WIDTH  register-file read addresses.
REQ-012 SHALL have ports rdata1, rdata2  input  DATA_WIDTH  register-file async read data.
REQ-013 SHALL have ports wb_valid input 1, wb_addr input ADDR_WIDTH, wb_data input DATA_WIDTH  writeback (same bus driving register-file write).
REQ-014 SHALL have ports out_valid output 1 / out_ready input 1  downstream execute handshake.
REQ-015 SHALL have ports out_pc, out_imm, out_src1, out_src2  output  DATA_WIDTH; out_ctrl output CTRL_WIDTH; out_rd output ADDR_WIDTH; out_rd_wen output 1.
REQ-016 SHALL have port idle  output  1  high when no busy bits set and out_valid low.

Function
REQ-017 SHALL drive raddr1=in_rs1, raddr2=in_rs2 combinationally every cycle.
REQ-018 SHALL keep scoreboard busy[2**ADDR_WIDTH-1:0]; busy[0] constant 0.
REQ-019 SHALL compute wbhit(r) = wb_valid && wb_addr==r && r!=0.
REQ-020 SHALL compute hazard = in_valid && ((busy[rs1] && !wbhit(rs1)) || (busy[rs2] && !wbhit(rs2)) || (in_rd_wen && busy[rd] && !wbhit(rd))); RAW and WAW both stall.
REQ-021 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, combinationally.
REQ-022 SHALL define accept = in_valid && in_ready; on accept latch all payload into output registers and set out_valid=1 next cycle.
REQ-023 SHALL select each source: index 0 -> 0; else wbhit -> wb_data (bypass); else rdata.
REQ-024 SHALL, on accept with in_rd_wen && in_rd!=0, set busy[in_rd] next cycle.
REQ-025 SHALL, on wb_valid && wb_addr!=0, clear busy[wb_addr] next cycle; wb to a non-busy register is a no-op.
REQ-026 SHALL give set priority over clear when both target the same register in one cycle.
REQ-027 SHALL clear out_valid when out_ready && out_valid && !accept; hold all outputs stable while out_valid && !out_ready.
REQ-028 SHALL give issue latency of one cycle: accept in cycle N -> out_valid in N+1; back-to-back accepts allowed when out_ready=1.
REQ-029 SHALL never let in_ready depend on out_ready except via the (!out_valid || out_ready) term; no combinational path from wb_* to out_* registers other than through capture.
REQ-030 SHALL treat in_rd_wen with in_rd==0 as no write (no busy set, no WAW stall).

Reset
REQ-031 SHALL, when rst high at posedge, clear out_valid, all busy bits, and all output payload registers to 0, overriding any concurrent accept or writeback.
REQ-032 SHALL present in_ready=1 and idle=1 in the first cycle after reset deasserts (given out_ready=1, in_valid=0).

Verification
REQ-033 SHALL cover: rst 1 cycle -> out_valid=0, idle=1, in_ready=1, out_src1=0.
REQ-034 SHALL cover: issue rd=5 wen=1, then rs1=5 with no wb -> in_ready=0 held; wb_valid=1 wb_addr=5 wb_data=0xDEADBEEF -> accept same cycle, out_src1=0xDEADBEEF next cycle.
REQ-035 SHALL cover: rs1=0, rs2=0 with wb_addr=0 wb_data=0x1234 -> out_src1=out_src2=0, no stall.
REQ-036 SHALL cover: out_ready=0 with out_valid=1 -> in_ready=0, outputs unchanged 3 cycles; out_ready=1 -> next instruction accepted, back-to-back at 1/cycle.
REQ-037 SHALL cover: busy[7]=1, new instr rd=7 wen=1 while wb_addr=7 -> accepted, busy[7] remains 1 (set wins); second wb to 7 -> busy[7]=0, idle=1 once out drains.
REQ-038 SHALL cover: rst asserted with busy[3]=1 and out_valid=1 -> all busy cleared, out_valid=0 next cycle.
